// File: rtl/state_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : state_dump_unit
// Brief    : Cycle counter and halt detector for the pipelined CPU. On a halt
//            condition or a one-shot request it freezes the CPU and streams a
//            register-file + data-memory snapshot over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module state_dump_unit #(
    parameter int          DATA_W    = 32,
    parameter int          REG_CNT   = 32,
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] MEM_BASE  = 32'h0,
    parameter int          CYC_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       pc_i,
    input  logic              halt_en_i,
    input  logic [31:0]       halt_pc_i,
    input  logic [CYC_W-1:0]  max_cycles_i,
    input  logic              dump_req_i,
    output logic [4:0]        reg_rd_addr_o,
    input  logic [DATA_W-1:0] reg_rd_data_i,
    output logic [31:0]       mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              cpu_stall_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sel_o,
    output logic [7:0]        out_idx_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CYC_W-1:0]  out_cycle_o,
    output logic [CYC_W-1:0]  cycle_cnt_o,
    output logic              halted_o
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_DUMP_REG = 3'd1,
        S_DUMP_MEM = 3'd2,
        S_DRAIN    = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [7:0] c_REG_LAST = 8'(REG_CNT - 1);
    localparam logic [7:0] c_MEM_LAST = 8'(MEM_WORDS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_idx;
    logic                r_final;
    logic                r_valid;
    logic                r_sel;
    logic [7:0]          r_out_idx;
    logic [DATA_W-1:0]   r_data;
    logic [CYC_W-1:0]    r_out_cycle;
    logic [CYC_W-1:0]    r_cnt;
    logic                r_stall;
    logic                r_halted;

    logic [CYC_W-1:0]    w_cnt_inc;
    logic [CYC_W-1:0]    w_cnt_sat;
    logic                w_trig_halt;
    logic                w_start;
    logic                w_load;
    logic                w_last;
    logic [DATA_W-1:0]   w_load_data;

    // Unsaturated +1 is used for the limit compare; the counter itself saturates.
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_cnt_sat   = (&r_cnt) ? r_cnt : w_cnt_inc;
    assign w_trig_halt = (halt_en_i && (pc_i == halt_pc_i)) ||
                         ((max_cycles_i != '0) && (w_cnt_inc == max_cycles_i));
    assign w_load_data = (r_state == S_DUMP_REG) ? reg_rd_data_i : mem_rd_data_i;

    // Debug read ports only address the target array while it is being dumped.
    assign reg_rd_addr_o = (r_state == S_DUMP_REG) ? r_idx[4:0] : 5'd0;
    assign mem_rd_addr_o = (r_state == S_DUMP_MEM) ? (MEM_BASE + {22'd0, r_idx, 2'b00}) : 32'd0;

    assign cpu_stall_o = r_stall;
    assign out_valid_o = r_valid;
    assign out_sel_o   = r_sel;
    assign out_idx_o   = r_out_idx;
    assign out_data_o  = r_data;
    assign out_cycle_o = r_out_cycle;
    assign cycle_cnt_o = r_cnt;
    assign halted_o    = r_halted;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; a new entry loads whenever the output slot is free or being taken.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_trig_halt || dump_req_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DUMP_REG;
                end
            end
            S_DUMP_REG: begin
                if (!r_valid || out_ready_i) begin
                    w_load = 1'b1;
                    if (r_idx == c_REG_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = (MEM_WORDS == 0) ? S_DRAIN : S_DUMP_MEM;
                    end
                end
            end
            S_DUMP_MEM: begin
                if (!r_valid || out_ready_i) begin
                    w_load = 1'b1;
                    if (r_idx == c_MEM_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave only once the final entry has been taken and valid has dropped.
                if (!r_valid) w_state_nxt = r_final ? S_HALT : S_RUN;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Counter, snapshot capture, output register and registered status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_out_cycle <= '0;
            r_final     <= 1'b0;
            r_idx       <= 8'd0;
            r_valid     <= 1'b0;
            r_sel       <= 1'b0;
            r_out_idx   <= 8'd0;
            r_data      <= '0;
            r_stall     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            if (r_state == S_RUN) r_cnt <= w_cnt_sat;
            if (w_start) begin
                r_out_cycle <= w_cnt_sat;
                r_final     <= w_trig_halt;
                r_idx       <= 8'd0;
            end
            if (w_load) begin
                r_valid   <= 1'b1;
                r_sel     <= (r_state == S_DUMP_MEM);
                r_out_idx <= r_idx;
                r_data    <= w_load_data;
                r_idx     <= w_last ? 8'd0 : (r_idx + 8'd1);
            end else if ((r_state == S_DRAIN) && r_valid && out_ready_i) begin
                r_valid <= 1'b0;
            end
            r_stall  <= (w_state_nxt != S_RUN);
            r_halted <= (w_state_nxt == S_HALT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_state_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_state_dump_unit
// Brief    : Directed self-checking bench for state_dump_unit (4 regs, 2 mem
//            words) plus a register-only instance (MEM_WORDS = 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_state_dump_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_i = 32'd0;
    logic        halt_en_i = 1'b0;
    logic [31:0] halt_pc_i = 32'd0;
    logic [31:0] max_cycles_i = 32'd0;
    logic        dump_req_i = 1'b0;
    logic [4:0]  reg_rd_addr_o;
    logic [31:0] reg_rd_data_i;
    logic [31:0] mem_rd_addr_o;
    logic [31:0] mem_rd_data_i;
    logic        cpu_stall_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic        out_sel_o;
    logic [7:0]  out_idx_o;
    logic [31:0] out_data_o;
    logic [31:0] out_cycle_o;
    logic [31:0] cycle_cnt_o;
    logic        halted_o;

    // register-only instance
    logic        dump_req0 = 1'b0;
    logic [4:0]  reg_addr0;
    logic [31:0] reg_data0;
    logic [31:0] mem_addr0;
    logic        stall0, valid0, sel0, halted0;
    logic [7:0]  idx0;
    logic [31:0] data0, cyc0, cnt0;

    logic [31:0] regs [32];
    logic [31:0] mems [32];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_data [6];
    logic        exp_sel  [6];
    logic [7:0]  exp_idx  [6];

    always #5 clk_i = ~clk_i;

    assign reg_rd_data_i = regs[reg_rd_addr_o];
    assign mem_rd_data_i = mems[mem_rd_addr_o[6:2]];
    assign reg_data0     = regs[reg_addr0];

    state_dump_unit #(.DATA_W(32), .REG_CNT(4), .MEM_WORDS(2), .MEM_BASE(32'h0), .CYC_W(32)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .halt_en_i(halt_en_i), .halt_pc_i(halt_pc_i),
        .max_cycles_i(max_cycles_i), .dump_req_i(dump_req_i),
        .reg_rd_addr_o(reg_rd_addr_o), .reg_rd_data_i(reg_rd_data_i),
        .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .cpu_stall_o(cpu_stall_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sel_o(out_sel_o), .out_idx_o(out_idx_o), .out_data_o(out_data_o),
        .out_cycle_o(out_cycle_o), .cycle_cnt_o(cycle_cnt_o), .halted_o(halted_o)
    );

    state_dump_unit #(.DATA_W(32), .REG_CNT(4), .MEM_WORDS(0), .MEM_BASE(32'h0), .CYC_W(32)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(32'd0), .halt_en_i(1'b0), .halt_pc_i(32'd0),
        .max_cycles_i(32'd0), .dump_req_i(dump_req0),
        .reg_rd_addr_o(reg_addr0), .reg_rd_data_i(reg_data0),
        .mem_rd_addr_o(mem_addr0), .mem_rd_data_i(32'd0),
        .cpu_stall_o(stall0), .out_valid_o(valid0), .out_ready_i(1'b1),
        .out_sel_o(sel0), .out_idx_o(idx0), .out_data_o(data0),
        .out_cycle_o(cyc0), .cycle_cnt_o(cnt0), .halted_o(halted0)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until the live counter reaches target (bounded).
    task automatic wait_cnt(input logic [31:0] target);
        for (int i = 0; i < 200; i++) begin
            if (cycle_cnt_o == target) break;
            tick();
        end
        chk("wait_cnt", cycle_cnt_o, target);
    endtask

    // Consume one dump; mode 1 drives ready with the repeating pattern 1,0,0,1.
    task automatic collect(input int mode, output int stall_cyc);
        int          n_acc;
        int          k;
        logic        hold;
        logic        h_sel;
        logic [7:0]  h_idx;
        logic [31:0] h_data;
        n_acc = 0; k = 0; hold = 1'b0; stall_cyc = 0;
        h_sel = 1'b0; h_idx = 8'd0; h_data = 32'd0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!cpu_stall_o || halted_o) break;
            stall_cyc++;
            out_ready_i = (mode == 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
            k++;
            if (hold) begin
                chk("hold_valid", out_valid_o, 1'b1);
                chk("hold_entry", {out_sel_o, out_idx_o, out_data_o}, {h_sel, h_idx, h_data});
            end
            if (out_valid_o && out_ready_i) begin
                if (n_acc < 6) begin
                    chk("entry", {out_sel_o, out_idx_o, out_data_o},
                        {exp_sel[n_acc], exp_idx[n_acc], exp_data[n_acc]});
                end
                n_acc++;
                hold = 1'b0;
            end else if (out_valid_o) begin
                hold = 1'b1;
                h_sel = out_sel_o; h_idx = out_idx_o; h_data = out_data_o;
            end else begin
                hold = 1'b0;
            end
            tick();
        end
        out_ready_i = 1'b1;
        chk("accepted", n_acc, 6);
        chk("valid_after", out_valid_o, 1'b0);
    endtask

    initial begin
        int st;
        logic [31:0] c0;
        for (int i = 0; i < 32; i++) begin regs[i] = 32'd0; mems[i] = 32'd0; end
        regs[0] = 32'd0; regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'd9;
        mems[0] = 32'd3; mems[1] = 32'd4;
        exp_sel[0] = 0; exp_idx[0] = 0; exp_data[0] = 0;
        exp_sel[1] = 0; exp_idx[1] = 1; exp_data[1] = 5;
        exp_sel[2] = 0; exp_idx[2] = 2; exp_data[2] = 7;
        exp_sel[3] = 0; exp_idx[3] = 3; exp_data[3] = 9;
        exp_sel[4] = 1; exp_idx[4] = 0; exp_data[4] = 3;
        exp_sel[5] = 1; exp_idx[5] = 1; exp_data[5] = 4;

        // Reset state
        tick(); tick();
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_cnt", cycle_cnt_o, 32'd0);
        chk("rst_halted", halted_o, 1'b0);
        chk("rst_cycle", out_cycle_o, 32'd0);
        chk("rst_addrs", {reg_rd_addr_o, mem_rd_addr_o}, 37'd0);
        rst_i = 1'b0;

        // One-shot dump at cycle 10, ready held high
        wait_cnt(32'd9);
        dump_req_i = 1'b1; tick(); dump_req_i = 1'b0;
        chk("req_cycle", out_cycle_o, 32'd10);
        chk("req_stall", cpu_stall_o, 1'b1);
        chk("req_valid0", out_valid_o, 1'b0);
        collect(0, st);
        chk("req_stall_len", st, 8);
        chk("resume_cnt", cycle_cnt_o, 32'd10);
        chk("resume_halted", halted_o, 1'b0);
        tick();
        chk("resume_inc", cycle_cnt_o, 32'd11);

        // Reset in the middle of the memory phase
        wait_cnt(32'd14);
        dump_req_i = 1'b1; tick(); dump_req_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_sel", {out_valid_o, out_sel_o, out_idx_o}, {1'b1, 1'b1, 8'd0});
        chk("mid_mem_addr", mem_rd_addr_o, 32'd4);
        rst_i = 1'b1;
        tick();
        chk("arst_valid", out_valid_o, 1'b0);
        chk("arst_stall", cpu_stall_o, 1'b0);
        chk("arst_cnt", cycle_cnt_o, 32'd0);
        chk("arst_addr", mem_rd_addr_o, 32'd0);
        rst_i = 1'b0;

        // Backpressure dump (capture at cycle 5)
        wait_cnt(32'd4);
        dump_req_i = 1'b1; tick(); dump_req_i = 1'b0;
        chk("bp_cycle", out_cycle_o, 32'd5);
        collect(1, st);
        chk("bp_resume", {cpu_stall_o, halted_o}, 2'b00);

        // Cycle limit coinciding with a request: single final dump
        max_cycles_i = 32'd20;
        wait_cnt(32'd19);
        dump_req_i = 1'b1; tick(); dump_req_i = 1'b0;
        chk("lim_cycle", out_cycle_o, 32'd20);
        collect(0, st);
        chk("lim_stall_len", st, 8);
        chk("lim_halted", {halted_o, cpu_stall_o}, 2'b11);
        dump_req_i = 1'b1; tick(); dump_req_i = 1'b0;
        tick(); tick();
        chk("lim_ignore", {halted_o, cpu_stall_o, out_valid_o}, 3'b110);
        chk("lim_frozen", {cycle_cnt_o, out_cycle_o}, {32'd20, 32'd20});

        // PC-match halt at 0x54
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        max_cycles_i = 32'd0;
        halt_en_i = 1'b1; halt_pc_i = 32'h54;
        wait_cnt(32'd7);
        pc_i = 32'h54; tick(); pc_i = 32'h0;
        chk("pc_cycle", out_cycle_o, 32'd8);
        chk("pc_stall", cpu_stall_o, 1'b1);
        collect(0, st);
        chk("pc_halted", halted_o, 1'b1);
        dump_req_i = 1'b1; tick(); dump_req_i = 1'b0;
        tick();
        chk("pc_ignore", {halted_o, cpu_stall_o, out_valid_o}, 3'b110);
        halt_en_i = 1'b0;

        // Register-only instance: four register entries, drain, run
        c0 = cnt0;
        dump_req0 = 1'b1; tick(); dump_req0 = 1'b0;
        chk("m0_cycle", cyc0, c0 + 32'd1);
        chk("m0_stall", stall0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("m0_entry", {valid0, sel0, idx0, data0}, {1'b1, 1'b0, 8'(i), regs[i]});
        end
        tick();
        chk("m0_drain", {valid0, stall0, mem_addr0}, {1'b0, 1'b1, 32'd0});
        tick();
        chk("m0_run", {stall0, halted0, cnt0}, {1'b0, 1'b0, c0 + 32'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
